riscv_hazard_ctrl: RTL and testbench
====================================

Name: riscv_hazard_ctrl

Overview:
- Pipeline scheduler for the 5-stage RV32I core; sole source of per-stage stall/flush strobes (F, D, E, M, W) and the E-stage forwarding selects.
- Resolves three hazard classes:
  - load-use (stall, then bubble);
  - taken branch/jump in E (flush D and E);
  - multi-cycle data-memory wait (freeze F–M, bubble into W).
- Small FSM for boot flush and memory-wait sequencing, with a wait-timeout watchdog.

Parameters:
- MEM_TIMEOUT, 255, max consecutive data-memory wait cycles before the timeout flag sets (1..65535).
- LOAD_RESULT_SRC, 2'b01, result_src encoding that marks an E-stage load.

Ports:
- i_clk  input  1  core clock; all state on rising edge
- i_rst  input  1  synchronous reset, active-high
- i_rs1_addrD  input  5  rs1 of instruction in D
- i_rs2_addrD  input  5  rs2 of instruction in D
- i_rs1_addrE  input  5  rs1 of instruction in E
- i_rs2_addrE  input  5  rs2 of instruction in E
- i_rd_addrE  input  5  rd of instruction in E
- i_ctrl_result_srcE  input  2  result source of instruction in E
- i_pc_srcE  input  1  branch taken / jal / jalr resolved in E
- i_rd_addrM  input  5  rd in M
- i_ctrl_reg_wr_enM  input  1  regfile write enable in M
- i_rd_addrW  input  5  rd in W
- i_ctrl_reg_wr_enW  input  1  regfile write enable in W
- i_dmem_busyM  input  1  data memory not ready for access in M
- o_hazard_stallF  output  1  hold PC
- o_hazard_stallD  output  1  hold F/D register
- o_hazard_flushD  output  1  clear F/D register
- o_hazard_stallE  output  1  hold D/E register
- o_hazard_flushE  output  1  clear D/E register
- o_hazard_stallM  output  1  hold E/M register
- o_hazard_flushW  output  1  clear M/W register (bubble)
- o_fwd_srcAE  output  2  E operand A select: 00 regfile, 01 W result, 10 M ALU result
- o_fwd_srcBE  output  2  E operand B select, same encoding
- o_hazard_timeout  output  1  sticky: memory wait exceeded MEM_TIMEOUT

Behaviour:
- Reset: synchronous, active-high. While i_rst=1:
  - state=S_BOOT, wait counter=0, o_hazard_timeout=0;
  - all stall outputs 0; flushD=flushE=1; flushW=1; fwd selects 00.
- States:
  - S_BOOT: one cycle after reset release. flushD=flushE=flushW=1, stalls 0. Next state S_RUN.
  - S_RUN:
    - If i_dmem_busyM=1: assert memory-wait outputs this cycle; next state S_MEMWAIT.
    - Else evaluate branch and load-use (below).
  - S_MEMWAIT:
    - stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=0.
    - On the first cycle with i_dmem_busyM=0: all outputs follow the S_RUN rules, next state S_RUN.
- Load-use (combinational, same cycle):
  - Condition: i_ctrl_result_srcE==LOAD_RESULT_SRC and i_rd_addrE!=0 and (i_rd_addrE==i_rs1_addrD or i_rd_addrE==i_rs2_addrD).
  - Response: stallF=stallD=1, flushE=1.
  - Exactly one bubble: the next cycle the load is in M and the condition no longer holds.
- Branch: i_pc_srcE=1 → flushD=flushE=1, stallF=stallD=0.
- Priority: memory wait > branch > load-use.
  - Branch plus load-use together: branch wins; the D instruction is discarded.
  - Branch during S_MEMWAIT: deferred. E is frozen, so i_pc_srcE persists and takes effect on the exit cycle.
- Forwarding, operand A (B identical using i_rs2_addrE):
  - 10 if i_ctrl_reg_wr_enM and i_rd_addrM!=0 and i_rd_addrM==i_rs1_addrE;
  - else 01 if i_ctrl_reg_wr_enW and i_rd_addrW!=0 and i_rd_addrW==i_rs1_addrE;
  - else 00.
  - M has priority over W. Selects are evaluated in every state.
- Wait counter:
  - Increments each S_MEMWAIT cycle, saturating at MEM_TIMEOUT. Cleared on entry to S_RUN.
  - When it reaches MEM_TIMEOUT, o_hazard_timeout goes to 1 the following cycle and stays set until i_rst.
  - FSM keeps waiting; the flag does not force exit.
- x0 is never a hazard source for load-use or forwarding.
- Reset mid-wait: next edge returns to S_BOOT; the counter clears but the timeout flag also clears (reset only).

Optional Feature:
- Macro RISCV_HAZARD_PERF_EN.
- Defined: adds outputs o_perf_stall_cnt[31:0] and o_perf_flush_cnt[31:0].
  - stall count: +1 per cycle with stallD=1.
  - flush count: +1 per cycle with i_pc_srcE=1 in S_RUN.
  - Both wrap modulo 2^32 and reset to 0 on i_rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: hold i_rst 3 cycles, release → flushD=flushE=flushW=1 for exactly one cycle after release, then all 0, timeout=0.
- Load-use: E=lw x5 (result_src=01, rdE=5), D rs1=5 → stallF=stallD=flushE=1 one cycle. Next cycle rdM=5, wrenM=1, rs1E=5 → fwdA=10.
- Branch plus load-use in the same cycle: pc_srcE=1 with the above load-use → flushD=flushE=1, stallF=stallD=0.
- Forwarding priority: rdM=rdW=7, both wren=1, rs2E=7 → fwdB=10; wrenM=0 → 01; rdM=rdW=0 → 00.
- Memory wait: busy high 4 cycles with pc_srcE=1 → stallF/D/E/M=1, flushW=1, flushD=flushE=0 for 4 cycles; exit cycle flushD=flushE=1.
- Timeout: MEM_TIMEOUT=3, busy held 6 cycles → timeout rises on the cycle after the counter reaches 3, stays 1 after busy drops, clears only on i_rst.

Source files
------------

// File: rtl/riscv_hazard_ctrl.sv
// Hazard scheduler for the 5-stage RV32I pipeline: stall/flush strobes and E-stage forwarding selects.
// Optional build macro RISCV_HAZARD_PERF_EN adds free-running stall/flush event counters.
module riscv_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT     = 255,
    parameter logic [1:0]  LOAD_RESULT_SRC = 2'b01
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [4:0] i_rs1_addrD,
    input  logic [4:0] i_rs2_addrD,
    input  logic [4:0] i_rs1_addrE,
    input  logic [4:0] i_rs2_addrE,
    input  logic [4:0] i_rd_addrE,
    input  logic [1:0] i_ctrl_result_srcE,
    input  logic       i_pc_srcE,
    input  logic [4:0] i_rd_addrM,
    input  logic       i_ctrl_reg_wr_enM,
    input  logic [4:0] i_rd_addrW,
    input  logic       i_ctrl_reg_wr_enW,
    input  logic       i_dmem_busyM,
    output logic       o_hazard_stallF,
    output logic       o_hazard_stallD,
    output logic       o_hazard_flushD,
    output logic       o_hazard_stallE,
    output logic       o_hazard_flushE,
    output logic       o_hazard_stallM,
    output logic       o_hazard_flushW,
    output logic [1:0] o_fwd_srcAE,
    output logic [1:0] o_fwd_srcBE,
    output logic       o_hazard_timeout
`ifdef RISCV_HAZARD_PERF_EN
    ,
    output logic [31:0] o_perf_stall_cnt,
    output logic [31:0] o_perf_flush_cnt
`endif
);

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_RUN     = 2'd1,
        S_MEMWAIT = 2'd2
    } state_t;

    localparam logic [15:0] TIMEOUT_VAL = 16'(MEM_TIMEOUT);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        load_use;

    // x0 is hardwired to zero, so a write to it can never be a forwarding source.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                           input logic [4:0] rd_m, input logic wr_m,
                                           input logic [4:0] rd_w, input logic wr_w);
        if (wr_m && rd_m != 5'd0 && rd_m == rs)
            return 2'b10;
        else if (wr_w && rd_w != 5'd0 && rd_w == rs)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign load_use = (i_ctrl_result_srcE == LOAD_RESULT_SRC) && (i_rd_addrE != 5'd0) &&
                      ((i_rd_addrE == i_rs1_addrD) || (i_rd_addrE == i_rs2_addrD));

    // NOTE: every output gets a default before the priority chain so no path leaves one unassigned (no latch).
    always_comb begin
        o_hazard_stallF = 1'b0;
        o_hazard_stallD = 1'b0;
        o_hazard_flushD = 1'b0;
        o_hazard_stallE = 1'b0;
        o_hazard_flushE = 1'b0;
        o_hazard_stallM = 1'b0;
        o_hazard_flushW = 1'b0;
        o_fwd_srcAE     = 2'b00;
        o_fwd_srcBE     = 2'b00;
        if (i_rst) begin
            o_hazard_flushD = 1'b1;
            o_hazard_flushE = 1'b1;
            o_hazard_flushW = 1'b1;
        end else begin
            o_fwd_srcAE = fwd_sel(i_rs1_addrE, i_rd_addrM, i_ctrl_reg_wr_enM,
                                  i_rd_addrW, i_ctrl_reg_wr_enW);
            o_fwd_srcBE = fwd_sel(i_rs2_addrE, i_rd_addrM, i_ctrl_reg_wr_enM,
                                  i_rd_addrW, i_ctrl_reg_wr_enW);
            if (state == S_BOOT) begin
                o_hazard_flushD = 1'b1;
                o_hazard_flushE = 1'b1;
                o_hazard_flushW = 1'b1;
            end else if (i_dmem_busyM) begin
                // Freeze F..M; a pending branch in E stays frozen and resolves on the exit cycle.
                o_hazard_stallF = 1'b1;
                o_hazard_stallD = 1'b1;
                o_hazard_stallE = 1'b1;
                o_hazard_stallM = 1'b1;
                o_hazard_flushW = 1'b1;
            end else if (i_pc_srcE) begin
                o_hazard_flushD = 1'b1;
                o_hazard_flushE = 1'b1;
            end else if (load_use) begin
                o_hazard_stallF = 1'b1;
                o_hazard_stallD = 1'b1;
                o_hazard_flushE = 1'b1;
            end
        end
    end

    // NOTE: all registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state            <= S_BOOT;
            wait_cnt         <= 16'd0;
            o_hazard_timeout <= 1'b0;
`ifdef RISCV_HAZARD_PERF_EN
            o_perf_stall_cnt <= 32'd0;
            o_perf_flush_cnt <= 32'd0;
`endif
        end else begin
            case (state)
                S_BOOT: state <= S_RUN;
                S_RUN: begin
                    if (i_dmem_busyM)
                        state <= S_MEMWAIT;
                end
                S_MEMWAIT: begin
                    if (!i_dmem_busyM) begin
                        state    <= S_RUN;
                        wait_cnt <= 16'd0;
                    end else if (wait_cnt != TIMEOUT_VAL) begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                default: state <= S_BOOT;
            endcase
            // Sticky until reset; the FSM keeps waiting regardless.
            if (wait_cnt == TIMEOUT_VAL)
                o_hazard_timeout <= 1'b1;
`ifdef RISCV_HAZARD_PERF_EN
            if (o_hazard_stallD)
                o_perf_stall_cnt <= o_perf_stall_cnt + 32'd1;
            if (state == S_RUN && i_pc_srcE)
                o_perf_flush_cnt <= o_perf_flush_cnt + 32'd1;
`else
            // Counters are compiled out in the default build.
`endif
        end
    end

endmodule

// File: tb/tb_riscv_hazard_ctrl.sv
// Self-checking bench for riscv_hazard_ctrl: directed literal checks plus randomized stimulus
// compared every cycle against a run-length based behavioural model.
module tb_riscv_hazard_ctrl;

    localparam int TB_T = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [1:0] srcE;
    logic       pcE, wrM, wrW, busy;

    logic       stallF, stallD, flushD, stallE, flushE, stallM, flushW;
    logic [1:0] fwdA, fwdB;
    logic       tout;
`ifdef RISCV_HAZARD_PERF_EN
    logic [31:0] perf_stall, perf_flush;
`endif

    riscv_hazard_ctrl #(.MEM_TIMEOUT(TB_T), .LOAD_RESULT_SRC(2'b01)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_rs1_addrD        (rs1D),
        .i_rs2_addrD        (rs2D),
        .i_rs1_addrE        (rs1E),
        .i_rs2_addrE        (rs2E),
        .i_rd_addrE         (rdE),
        .i_ctrl_result_srcE (srcE),
        .i_pc_srcE          (pcE),
        .i_rd_addrM         (rdM),
        .i_ctrl_reg_wr_enM  (wrM),
        .i_rd_addrW         (rdW),
        .i_ctrl_reg_wr_enW  (wrW),
        .i_dmem_busyM       (busy),
        .o_hazard_stallF    (stallF),
        .o_hazard_stallD    (stallD),
        .o_hazard_flushD    (flushD),
        .o_hazard_stallE    (stallE),
        .o_hazard_flushE    (flushE),
        .o_hazard_stallM    (stallM),
        .o_hazard_flushW    (flushW),
        .o_fwd_srcAE        (fwdA),
        .o_fwd_srcBE        (fwdB),
        .o_hazard_timeout   (tout)
`ifdef RISCV_HAZARD_PERF_EN
        ,
        .o_perf_stall_cnt   (perf_stall),
        .o_perf_flush_cnt   (perf_flush)
`endif
    );

    // Strobe vector order: {stallF, stallD, flushD, stallE, flushE, stallM, flushW}
    wire [6:0] vec = {stallF, stallD, flushD, stallE, flushE, stallM, flushW};
    localparam logic [6:0] V_FLUSH3 = 7'b0010101;
    localparam logic [6:0] V_WAIT   = 7'b1101011;
    localparam logic [6:0] V_BRANCH = 7'b0010100;
    localparam logic [6:0] V_LDUSE  = 7'b1100100;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] m_fwd(input logic [4:0] rs);
        if (wrM && rdM != 0 && rdM == rs) return 2'b10;
        if (wrW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic m_lu();
        return srcE == 2'b01 && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    endfunction

    function automatic logic [6:0] m_vec(input logic r, input logic boot);
        if (r || boot) return V_FLUSH3;
        if (busy)      return V_WAIT;
        if (pcE)       return V_BRANCH;
        if (m_lu())    return V_LDUSE;
        return 7'b0;
    endfunction

    // m_run: busy cycles in a row immediately before the current cycle (boot cycles excluded).
    logic        m_prev_rst = 1'b1;
    int          m_run      = 0;
    logic        m_sticky   = 1'b0;
    logic [31:0] m_stall    = 0;
    logic [31:0] m_flush    = 0;

    always @(posedge clk) begin
        logic       boot;
        logic [6:0] v;
        if (rst) begin
            m_prev_rst <= 1'b1;
            m_run      <= 0;
            m_sticky   <= 1'b0;
            m_stall    <= 0;
            m_flush    <= 0;
        end else begin
            boot = m_prev_rst;
            v    = m_vec(1'b0, boot);
            if (!boot && m_run >= TB_T + 1) m_sticky <= 1'b1;
            if (v[5]) m_stall <= m_stall + 1;
            if (!boot && m_run == 0 && pcE) m_flush <= m_flush + 1;
            m_run      <= (!boot && busy) ? m_run + 1 : 0;
            m_prev_rst <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic boot;
        boot = !rst && m_prev_rst;
        check("m_ctrl", {25'b0, vec}, {25'b0, m_vec(rst, boot)});
        check("m_fwdA", {30'b0, fwdA}, {30'b0, rst ? 2'b00 : m_fwd(rs1E)});
        check("m_fwdB", {30'b0, fwdB}, {30'b0, rst ? 2'b00 : m_fwd(rs2E)});
        check("m_timeout", {31'b0, tout}, {31'b0, m_sticky});
`ifdef RISCV_HAZARD_PERF_EN
        check("m_perf_stall", perf_stall, m_stall);
        check("m_perf_flush", perf_flush, m_flush);
`endif
    end

    // ---------------- directed helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_lit(input string name, input logic [6:0] v, input logic [1:0] fa,
                           input logic [1:0] fb, input logic to);
        @(negedge clk);
        check({name, "_ctrl"}, {25'b0, vec}, {25'b0, v});
        check({name, "_fwdA"}, {30'b0, fwdA}, {30'b0, fa});
        check({name, "_fwdB"}, {30'b0, fwdB}, {30'b0, fb});
        check({name, "_to"}, {31'b0, tout}, {31'b0, to});
    endtask

    task automatic clear_inputs();
        rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        srcE = 0; pcE = 0; wrM = 0; wrW = 0; busy = 0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        rdM = 5; wrM = 1; rs1E = 5;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk_lit("reset", V_FLUSH3, 2'b00, 2'b00, 1'b0);
        end
        cyc(); rst = 1'b0;
        chk_lit("boot", V_FLUSH3, 2'b10, 2'b00, 1'b0);
        cyc(); clear_inputs();
        chk_lit("idle", 7'b0, 2'b00, 2'b00, 1'b0);

        // load-use, then the load in M forwards
        cyc(); srcE = 2'b01; rdE = 5; rs1D = 5;
        chk_lit("load_use", V_LDUSE, 2'b00, 2'b00, 1'b0);
        cyc(); srcE = 0; rdE = 0; rs1D = 0; rdM = 5; wrM = 1; rs1E = 5;
        chk_lit("ld_fwd", 7'b0, 2'b10, 2'b00, 1'b0);

        // branch wins over load-use
        cyc(); rdM = 0; wrM = 0; rs1E = 0; srcE = 2'b01; rdE = 5; rs2D = 5; pcE = 1;
        chk_lit("br_lu", V_BRANCH, 2'b00, 2'b00, 1'b0);
        cyc(); pcE = 0; rdE = 0; rs2D = 0;
        chk_lit("x0_load", 7'b0, 2'b00, 2'b00, 1'b0);

        // forwarding priority
        cyc(); srcE = 0; rdM = 7; rdW = 7; wrM = 1; wrW = 1; rs2E = 7;
        chk_lit("fwd_m", 7'b0, 2'b00, 2'b10, 1'b0);
        cyc(); wrM = 0;
        chk_lit("fwd_w", 7'b0, 2'b00, 2'b01, 1'b0);
        cyc(); rdM = 0; rdW = 0; wrM = 1;
        chk_lit("fwd_x0", 7'b0, 2'b00, 2'b00, 1'b0);

        // 4-cycle memory wait with a deferred branch; T+1 busy cycles trips the watchdog
        cyc(); clear_inputs(); busy = 1; pcE = 1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) cyc();
            chk_lit("memwait", V_WAIT, 2'b00, 2'b00, 1'b0);
        end
        cyc(); busy = 0;
        chk_lit("mw_exit", V_BRANCH, 2'b00, 2'b00, 1'b0);
        cyc(); pcE = 0;
        chk_lit("sticky4", 7'b0, 2'b00, 2'b00, 1'b1);

        // reset clears the flag only at the clock edge
        cyc(); rst = 1;
        chk_lit("rst_hold", V_FLUSH3, 2'b00, 2'b00, 1'b1);
        cyc();
        chk_lit("rst_clr", V_FLUSH3, 2'b00, 2'b00, 1'b0);
        cyc(); rst = 0;
        chk_lit("boot2", V_FLUSH3, 2'b00, 2'b00, 1'b0);

        // exactly T busy cycles: no timeout
        cyc(); busy = 1;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) cyc();
            chk_lit("wait3", V_WAIT, 2'b00, 2'b00, 1'b0);
        end
        cyc(); busy = 0;
        chk_lit("wait3_exit", 7'b0, 2'b00, 2'b00, 1'b0);
        cyc();
        chk_lit("wait3_none", 7'b0, 2'b00, 2'b00, 1'b0);

        // 6 busy cycles: flag rises on the 6th, stays after busy drops
        cyc(); busy = 1;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) cyc();
            chk_lit("wait6", V_WAIT, 2'b00, 2'b00, k == 5);
        end
        cyc(); busy = 0;
        chk_lit("wait6_exit", 7'b0, 2'b00, 2'b00, 1'b1);
        cyc();
        chk_lit("wait6_hold", 7'b0, 2'b00, 2'b00, 1'b1);

        cyc(); rst = 1;
        cyc();
        cyc(); rst = 0;

        // randomized phase, checked by the model process
        for (int n = 0; n < 3000; n++) begin
            cyc();
            rst  = ($urandom_range(0, 249) == 0);
            busy = busy ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 2);
            rs1D = 5'($urandom_range(0, 7));
            rs2D = 5'($urandom_range(0, 7));
            rs1E = 5'($urandom_range(0, 7));
            rs2E = 5'($urandom_range(0, 7));
            rdE  = 5'($urandom_range(0, 7));
            rdM  = 5'($urandom_range(0, 7));
            rdW  = 5'($urandom_range(0, 7));
            srcE = 2'($urandom_range(0, 3));
            pcE  = ($urandom_range(0, 4) == 0);
            wrM  = 1'($urandom_range(0, 1));
            wrW  = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
